l2_cache: RTL and testbench

Unified L2 line cache answering the L1 data cache's 128-bit line-request port and issuing its own misses and write-backs to main memory over the same request/ready protocol. Direct-mapped, write-back, write-allocate. Full-line L1 writes never require a fetch. Sits between the L1 data cache and the memory model in the pipelined RISC-V extension.

---
 rtl/l2_cache.sv | 186 ++++++++++++++++++
 tb/tb_l2_cache.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_cache.sv
// l2_cache: direct-mapped write-back, write-allocate L2 line cache between L1 and memory.
// Define L2_STATS_EN to add the hit_cnt/miss_cnt counter outputs.
module l2_cache #(
  parameter int NUM_SET  = 64,
  parameter int SET_BITS = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         l1_read,
  input  logic         l1_write,
  input  logic [27:0]  l1_addr,
  input  logic [127:0] l1_wdata,
  output logic [127:0] l1_rdata,
  output logic         l1_ready,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
`ifdef L2_STATS_EN
  ,
  output logic [31:0]  hit_cnt,
  output logic [31:0]  miss_cnt
`endif
);

  localparam int TAG_BITS = 28 - SET_BITS;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMP   = 3'd1;
  localparam logic [2:0] S_WB    = 3'd2;
  localparam logic [2:0] S_FETCH = 3'd3;
  localparam logic [2:0] S_FILLW = 3'd4;
  localparam logic [2:0] S_RESP  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]          state;
  logic                op_wr;
  logic [27:0]         addr_q;
  logic [127:0]        wdata_q;

  logic [127:0]        data_q [NUM_SET];
  logic [TAG_BITS-1:0] tag_q  [NUM_SET];
  logic [NUM_SET-1:0]  valid_q;
  logic [NUM_SET-1:0]  dirty_q;

  logic [SET_BITS-1:0] set_idx;
  logic [TAG_BITS-1:0] req_tag;
  logic                hit;
  logic                vic_dirty;
  logic                c_rhit;
  logic                c_wr;
  logic                c_fetch;
  logic                c_wb;

  assign set_idx   = addr_q[SET_BITS-1:0];
  assign req_tag   = addr_q[27:SET_BITS];
  assign hit       = valid_q[set_idx] && (tag_q[set_idx] == req_tag);
  assign vic_dirty = valid_q[set_idx] && dirty_q[set_idx];

  // CMP outcomes, mutually exclusive and exhaustive
  assign c_rhit  = !op_wr && hit;
  assign c_wr    = op_wr && (hit || !vic_dirty);
  assign c_fetch = !op_wr && !hit && !vic_dirty;
  assign c_wb    = !hit && vic_dirty;

  assign l1_ready = (state == S_RESP);

  logic         arr_we;
  logic [127:0] arr_line;

  always_comb begin
    arr_we   = 1'b0;
    arr_line = wdata_q;
    if (state == S_CMP && c_wr) begin
      arr_we = 1'b1;
    end else if (state == S_FILLW) begin
      arr_we = 1'b1;
    end else if (state == S_FETCH && mem_ready) begin
      arr_we   = 1'b1;
      arr_line = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (arr_we) begin
      data_q[set_idx] <= arr_line;
      tag_q[set_idx]  <= req_tag;
    end
  end

  // Installs from a fetch are clean; installs of an L1 line are dirty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (arr_we) begin
      valid_q[set_idx] <= 1'b1;
      dirty_q[set_idx] <= op_wr;
    end else if (state == S_WB && mem_ready) begin
      dirty_q[set_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_wr     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      l1_rdata  <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (l1_read || l1_write) begin
            op_wr   <= l1_write;
            addr_q  <= l1_addr;
            wdata_q <= l1_wdata;
            state   <= S_CMP;
          end
        end
        S_CMP: begin
          unique case (1'b1)
            c_rhit: begin
              l1_rdata <= data_q[set_idx];
              state    <= S_RESP;
            end
            c_wr: state <= S_RESP;
            c_fetch: begin
              mem_read <= 1'b1;
              mem_addr <= addr_q;
              state    <= S_FETCH;
            end
            c_wb: begin
              mem_write <= 1'b1;
              mem_addr  <= {tag_q[set_idx], set_idx};
              mem_wdata <= data_q[set_idx];
              state     <= S_WB;
            end
          endcase
        end
        S_WB: begin
          if (mem_ready) begin
            mem_write <= 1'b0;
            if (op_wr) begin
              state <= S_FILLW;
            end else begin
              mem_read <= 1'b1;
              mem_addr <= addr_q;
              state    <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (mem_ready) begin
            mem_read <= 1'b0;
            l1_rdata <= mem_rdata;
            state    <= S_RESP;
          end
        end
        S_FILLW: state <= S_RESP;
        S_RESP:  state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef L2_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == S_CMP) begin
      if (hit) hit_cnt <= hit_cnt + 32'd1;
      else     miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_l2_cache.sv
// tb_l2_cache: randomized scoreboard bench for l2_cache with a memory responder
// and a line-level reference model of the cache and backing memory.
module tb_l2_cache;

  logic         clk;
  logic         rst_n;
  logic         l1_read;
  logic         l1_write;
  logic [27:0]  l1_addr;
  logic [127:0] l1_wdata;
  logic [127:0] l1_rdata;
  logic         l1_ready;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
`ifdef L2_STATS_EN
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;
`endif

  l2_cache dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .l1_read   (l1_read),
    .l1_write  (l1_write),
    .l1_addr   (l1_addr),
    .l1_wdata  (l1_wdata),
    .l1_rdata  (l1_rdata),
    .l1_ready  (l1_ready),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
`ifdef L2_STATS_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit           wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
  } mreq_t;

  // kind 0: ready 2 cycles after request; 1: 1 cycle after mem_ready; 2: unchecked
  typedef struct {
    int           kind;
    logic [127:0] rdata;
  } resp_t;

  mreq_t mem_q[$];
  resp_t scb_q[$];

  int checks = 0;
  int errors = 0;
  int ready_pulses = 0;
  int mem_rd_cnt = 0;
  int mem_wr_cnt = 0;
  int mem_lat = 3;
  int req_cyc = 0;
  int rdy_cyc = 0;
  bit spur = 0;

  logic [127:0] mem     [logic [27:0]];
  logic [127:0] ref_mem [logic [27:0]];

  bit           mv [64];
  bit           md [64];
  logic [21:0]  mt [64];
  logic [127:0] ml [64];
  logic [127:0] last_rd;
  int           m_hits;
  int           m_misses;

  function automatic logic [127:0] init_line(logic [27:0] a);
    logic [31:0] x;
    x = {4'h0, a};
    return {x ^ 32'hDEAD_0000, ~x, x * 32'd3 + 32'd7, x | 32'hC000_0000};
  endfunction

  function automatic logic [127:0] mem_get(logic [27:0] a);
    return mem.exists(a) ? mem[a] : init_line(a);
  endfunction

  function automatic logic [127:0] ref_get(logic [27:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_line(a);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) begin
      mv[i] = 0;
      md[i] = 0;
    end
    last_rd  = '0;
    m_hits   = 0;
    m_misses = 0;
  endfunction

  // One L1 request against the abstract cache: predicts downstream traffic and the reply
  function automatic void model_req(bit wr, logic [27:0] a, logic [127:0] wd);
    logic [5:0]  s;
    logic [21:0] t;
    bit          hit;
    bit          evict;
    mreq_t       m;
    resp_t       r;
    s     = a[5:0];
    t     = a[27:6];
    hit   = mv[s] && (mt[s] == t);
    evict = !hit && mv[s] && md[s];
    if (hit) m_hits++;
    else     m_misses++;
    if (evict) begin
      m.wr    = 1;
      m.addr  = {mt[s], s};
      m.wdata = ml[s];
      mem_q.push_back(m);
      ref_mem[m.addr] = ml[s];
      md[s] = 0;
    end
    if (wr) begin
      ml[s] = wd;
      mt[s] = t;
      mv[s] = 1;
      md[s] = 1;
      r.kind = evict ? 2 : 0;
    end else if (hit) begin
      last_rd = ml[s];
      r.kind  = 0;
    end else begin
      m.wr    = 0;
      m.addr  = a;
      m.wdata = '0;
      mem_q.push_back(m);
      ml[s]   = ref_get(a);
      mt[s]   = t;
      mv[s]   = 1;
      md[s]   = 0;
      last_rd = ml[s];
      r.kind  = 1;
    end
    r.rdata = last_rd;
    scb_q.push_back(r);
  endfunction

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: checks each downstream request against the model queue
  initial begin : responder
    mreq_t cur;
    mreq_t e;
    bit    busy;
    int    left;
    busy      = 0;
    left      = 0;
    mem_ready = 0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy      = 0;
        mem_ready = 0;
        continue;
      end
      if (mem_ready) mem_ready = 0;
      if (busy) begin
        left--;
        if (left <= 0) begin
          if (cur.wr) mem[cur.addr] = cur.wdata;
          else        mem_rdata = mem_get(cur.addr);
          mem_ready = 1;
          rdy_cyc   = cyc;
          busy      = 0;
        end
      end else if (mem_read || mem_write) begin
        chk("one_downstream_req", {127'd0, mem_read && mem_write}, 128'd0);
        cur.wr    = mem_write;
        cur.addr  = mem_addr;
        cur.wdata = mem_wdata;
        if (cur.wr) mem_wr_cnt++;
        else        mem_rd_cnt++;
        checks++;
        if (mem_q.size() == 0) begin
          errors++;
          $display("FAIL mem_req_unexpected: got wr=%0d addr=%h expected none",
                   cur.wr, cur.addr);
        end else begin
          e = mem_q.pop_front();
          if (e.wr != cur.wr || e.addr != cur.addr ||
              (e.wr && e.wdata != cur.wdata)) begin
            errors++;
            $display("FAIL mem_req: got wr=%0d addr=%h data=%h expected wr=%0d addr=%h data=%h",
                     cur.wr, cur.addr, cur.wdata, e.wr, e.addr, e.wdata);
          end
        end
        left = mem_lat;
        busy = 1;
      end else if (spur) begin
        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        mem_ready = 1;
        spur      = 0;
      end
    end
  end

  // Monitor: pops the expected reply whenever l1_ready is seen
  initial begin : monitor
    resp_t r;
    forever begin
      @(negedge clk);
      if (rst_n && l1_ready) begin
        ready_pulses++;
        if (scb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL l1_ready_unexpected: got pulse expected none");
        end else begin
          r = scb_q.pop_front();
          chk("l1_rdata", l1_rdata, r.rdata);
          if (r.kind == 0)
            chk("hit_latency", 128'(cyc - req_cyc), 128'd2);
          else if (r.kind == 1)
            chk("miss_latency", 128'(cyc - rdy_cyc), 128'd1);
        end
      end
    end
  end

  task automatic do_req(input bit wr, input logic [27:0] a,
                        input logic [127:0] wd, input bit hold);
    int n;
    bit got;
    @(negedge clk);
    model_req(wr, a, wd);
    l1_read  = !wr;
    l1_write = wr;
    l1_addr  = a;
    l1_wdata = wd;
    req_cyc  = cyc;
    n   = 0;
    got = 0;
    while (!got && n < 300) begin
      @(negedge clk);
      if (l1_ready) got = 1;
      else n++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: got no l1_ready expected one for addr %h", a);
    end
    if (hold) @(negedge clk);
    l1_read  = 0;
    l1_write = 0;
    @(negedge clk);
  endtask

  localparam logic [127:0] LINE_AA = {16{8'hAA}};
  localparam logic [127:0] LINE_55 = {16{8'h55}};

  initial begin : driver
    int rd0;
    int wr0;
    int rp0;
    int n;
    rst_n    = 0;
    l1_read  = 0;
    l1_write = 0;
    l1_addr  = '0;
    l1_wdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_l1_ready", {127'd0, l1_ready}, 128'd0);
    chk("rst_l1_rdata", l1_rdata, 128'd0);
    chk("rst_mem_read", {127'd0, mem_read}, 128'd0);
    chk("rst_mem_write", {127'd0, mem_write}, 128'd0);
    chk("rst_mem_addr", {100'd0, mem_addr}, 128'd0);
    chk("rst_mem_wdata", mem_wdata, 128'd0);
    @(negedge clk);
    rst_n = 1;

    mem_lat = 3;
    do_req(0, 28'h0000040, '0, 0);
    chk("first_miss_reads", 128'(mem_rd_cnt), 128'd1);
    do_req(0, 28'h0000040, '0, 0);
    chk("reread_no_mem", 128'(mem_rd_cnt), 128'd1);

    rd0 = mem_rd_cnt;
    wr0 = mem_wr_cnt;
    do_req(1, 28'h0000040, LINE_AA, 0);
    do_req(0, 28'h0000040, '0, 0);
    chk("write_hit_no_mem", 128'(mem_rd_cnt + mem_wr_cnt), 128'(rd0 + wr0));

    rp0 = ready_pulses;
    do_req(0, 28'h0000080, '0, 0);
    chk("evict_wb_count", 128'(mem_wr_cnt), 128'd1);
    chk("evict_fetch_count", 128'(mem_rd_cnt), 128'd2);
    chk("evict_one_ready", 128'(ready_pulses - rp0), 128'd1);

    rp0 = ready_pulses;
    rd0 = mem_rd_cnt;
    do_req(0, 28'h0000100, '0, 1);
    repeat (6) @(negedge clk);
    chk("hold_one_ready", 128'(ready_pulses - rp0), 128'd1);
    chk("hold_one_fetch", 128'(mem_rd_cnt - rd0), 128'd1);

    spur = 1;
    repeat (3) @(negedge clk);
    do_req(0, 28'h0000100, '0, 0);
    do_req(1, 28'h0000100, LINE_55, 0);
    do_req(1, 28'h0000100, LINE_AA, 0);
    do_req(0, 28'h0000100, '0, 0);

    mem_lat = 10;
    @(negedge clk);
    model_req(0, 28'h0000245, '0);
    l1_read = 1;
    l1_addr = 28'h0000245;
    n = 0;
    while (!mem_read && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("fetch_started", {127'd0, mem_read}, 128'd1);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("async_rst_mem_read", {127'd0, mem_read}, 128'd0);
    chk("async_rst_mem_addr", {100'd0, mem_addr}, 128'd0);
    l1_read = 0;
    mem_q.delete();
    scb_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    rd0 = mem_rd_cnt;
    mem_lat = 2;
    do_req(0, 28'h0000245, '0, 0);
    chk("miss_after_reset", 128'(mem_rd_cnt - rd0), 128'd1);

    for (int i = 0; i < 250; i++) begin
      logic [27:0]  a;
      logic [127:0] wd;
      a  = 28'(($urandom_range(0, 3) << 6) | $urandom_range(0, 3));
      wd = {$urandom, $urandom, $urandom, $urandom};
      mem_lat = $urandom_range(1, 5);
      do_req(1'($urandom_range(0, 1)), a, wd, 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 128'(scb_q.size()), 128'd0);
    chk("mem_queue_drained", 128'(mem_q.size()), 128'd0);
`ifdef L2_STATS_EN
    chk("hit_cnt", {96'd0, hit_cnt}, 128'(m_hits));
    chk("miss_cnt", {96'd0, miss_cnt}, 128'(m_misses));
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
